// File: rtl/uart_debug_cmd_if.sv
// rtl/uart_debug_cmd_if.sv - uart rx/tx byte handshake between the uart and the debug command engine
interface uart_debug_cmd_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  // uart side: delivers received bytes, accepts bytes to send
  modport master (
    output received,
    output rx_byte,
    output is_transmitting,
    input  transmit,
    input  tx_byte
  );

  // command engine side
  modport slave (
    input  received,
    input  rx_byte,
    input  is_transmitting,
    output transmit,
    output tx_byte
  );
endinterface

// File: rtl/uart_debug_cmd.sv
// rtl/uart_debug_cmd.sv - uart byte-protocol debug command engine (optional inter-byte timeout: UART_DEBUG_CMD_TIMEOUT_EN)
module uart_debug_cmd #(
  parameter int NUM_PROBES     = 4,
  parameter int NUM_REGS       = 4,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic                    iCE_CLK,
  input  logic                    rst_n,
  uart_debug_cmd_if.slave         uart,
  input  logic [8*NUM_PROBES-1:0] probe_in,
  output logic [8*NUM_REGS-1:0]   ctrl_out,
  output logic                    busy,
  output logic                    cmd_error
);

  localparam logic [7:0] OP_PING  = 8'h50;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_CTRL  = 8'h43;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_PONG = 8'h4B;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_EXEC, S_SEND, S_WAIT_TX
  } state_t;

  state_t                        state_q, state_d;
  logic [7:0]                    opcode_q, opcode_d;
  logic [7:0]                    addr_q, addr_d;
  logic [7:0]                    data_q, data_d;
  logic [7:0]                    tx_byte_q, tx_byte_d;
  logic [NUM_REGS-1:0][7:0]      ctrl_q, ctrl_d;
  logic [1:0]                    wait_q, wait_d;
  logic                          err_q, err_d;
  logic                          transmit_c;
  logic [7:0]                    probe_sel, ctrl_sel;
`ifdef UART_DEBUG_CMD_TIMEOUT_EN
  logic [31:0]                   tmo_q, tmo_d;
`endif

  assign uart.transmit = transmit_c;
  assign uart.tx_byte  = tx_byte_q;
  assign ctrl_out      = ctrl_q;
  assign busy          = (state_q != S_IDLE);
  assign cmd_error     = err_q;

  // byte mux for the addressed probe and control register (addr is range-checked separately)
  always_comb begin
    probe_sel = 8'h00;
    ctrl_sel  = 8'h00;
    for (int k = 0; k < NUM_PROBES; k++)
      if (addr_q == 8'(k)) probe_sel = probe_in[8*k +: 8];
    for (int k = 0; k < NUM_REGS; k++)
      if (addr_q == 8'(k)) ctrl_sel = ctrl_q[k];
  end

  // command FSM: byte collection, execution, response hand-off to the uart
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_byte_d  = tx_byte_q;
    ctrl_d     = ctrl_q;
    wait_d     = wait_q;
    err_d      = 1'b0;
    transmit_c = 1'b0;
`ifdef UART_DEBUG_CMD_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        wait_d = 2'd0;
        if (uart.received) begin
          opcode_d = uart.rx_byte;
          if (uart.rx_byte == OP_READ || uart.rx_byte == OP_CTRL || uart.rx_byte == OP_WRITE)
            state_d = S_GET_ADDR;
          else
            state_d = S_EXEC;
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        if (uart.received) begin
          if (state_q == S_GET_ADDR) begin
            addr_d  = uart.rx_byte;
            state_d = (opcode_q == OP_WRITE) ? S_GET_DATA : S_EXEC;
          end else begin
            data_d  = uart.rx_byte;
            state_d = S_EXEC;
          end
        end
`ifdef UART_DEBUG_CMD_TIMEOUT_EN
        // silence counter; a received byte restarts it, expiry abandons the command silently
        else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      S_EXEC: begin
        err_d = uart.received;
        case (opcode_q)
          OP_PING:  tx_byte_d = RSP_PONG;
          OP_READ:  tx_byte_d = (int'(addr_q) < NUM_PROBES) ? probe_sel : RSP_NAK;
          OP_CTRL:  tx_byte_d = (int'(addr_q) < NUM_REGS) ? ctrl_sel : RSP_NAK;
          OP_WRITE: begin
            tx_byte_d = (int'(addr_q) < NUM_REGS) ? RSP_ACK : RSP_NAK;
            for (int k = 0; k < NUM_REGS; k++)
              if (addr_q == 8'(k)) ctrl_d[k] = data_q;
          end
          default:  tx_byte_d = RSP_NAK;
        endcase
        if (tx_byte_d == RSP_NAK && opcode_q != OP_READ && opcode_q != OP_CTRL)
          err_d = 1'b1;
        if ((opcode_q == OP_READ && int'(addr_q) >= NUM_PROBES) ||
            (opcode_q == OP_CTRL && int'(addr_q) >= NUM_REGS))
          err_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        err_d = uart.received;
        if (!uart.is_transmitting) begin
          transmit_c = 1'b1;
          wait_d     = 2'd0;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // the uart raises is_transmitting a couple of cycles after the pulse, so skip those first
        err_d = uart.received;
        if (wait_q < 2'd2)
          wait_d = wait_q + 2'd1;
        else if (!uart.is_transmitting)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and holding registers
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      tx_byte_q <= 8'h00;
      ctrl_q    <= '0;
      wait_q    <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_byte_q <= tx_byte_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
    end
  end

`ifdef UART_DEBUG_CMD_TIMEOUT_EN
  // inter-byte timeout counter
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_uart_debug_cmd.sv
// tb/tb_uart_debug_cmd.sv - directed self-checking bench for uart_debug_cmd
module tb_uart_debug_cmd;
`ifdef UART_DEBUG_CMD_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 120000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] probe_in = 32'h0;
  logic [31:0] ctrl_out;
  logic        busy, cmd_error;
  logic        hold_busy = 1'b0;
  int          busy_cnt = 0;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rx_cyc = 0, tx_cyc = 0, tx_cnt = 0, err_cnt = 0;
  logic [7:0] tx_val = 8'h00;
  int tx0, err0;

  uart_debug_cmd_if u_if ();

  uart_debug_cmd #(.NUM_PROBES(4), .NUM_REGS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .iCE_CLK  (clk),
    .rst_n    (rst_n),
    .uart     (u_if.slave),
    .probe_in (probe_in),
    .ctrl_out (ctrl_out),
    .busy     (busy),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_if.transmit) busy_cnt <= 6;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign u_if.is_transmitting = hold_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (u_if.received) rx_cyc = cyc;
    if (u_if.transmit) begin
      tx_cnt++;
      tx_cyc = cyc;
      tx_val = u_if.tx_byte;
    end
    if (cmd_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    u_if.received = 1'b1;
    u_if.rx_byte  = b;
    @(posedge clk); #1;
    u_if.received = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input int n, input logic [7:0] b0, b1, b2,
                         input logic [7:0] exp_rsp, input int exp_err);
    tx0  = tx_cnt;
    err0 = err_cnt;
    send_byte(b0);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    wait_idle(tag);
    repeat (2) @(negedge clk);
    chk({tag, "_txcnt"}, 32'(tx_cnt - tx0), 32'd1);
    chk({tag, "_rsp"}, 32'(tx_val), 32'(exp_rsp));
    chk({tag, "_err"}, 32'(err_cnt - err0), 32'(exp_err));
  endtask

  initial begin
    u_if.received = 1'b0;
    u_if.rx_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_transmit", 32'(u_if.transmit), 32'd0);
    chk("rst_tx_byte", 32'(u_if.tx_byte), 32'h00);
    chk("rst_ctrl", ctrl_out, 32'h0);
    chk("rst_err", 32'(cmd_error), 32'd0);
    rst_n = 1'b1;

    run_cmd("ping", 1, 8'h50, 8'h00, 8'h00, 8'h4B, 0);
    chk("ping_latency", 32'(tx_cyc - rx_cyc), 32'd2);
    chk("ping_busy", 32'(busy), 32'd0);

    run_cmd("write", 3, 8'h57, 8'h02, 8'hA5, 8'h06, 0);
    chk("write_ctrl", ctrl_out, 32'h00A5_0000);
    run_cmd("ctrl_rd", 2, 8'h43, 8'h02, 8'h00, 8'hA5, 0);
    run_cmd("ctrl_rd0", 2, 8'h43, 8'h00, 8'h00, 8'h00, 0);

    // probe snapshot: byte1 changes right after the EXEC cycle
    probe_in = 32'h1100_3C22;
    tx0 = tx_cnt;
    send_byte(8'h52);
    send_byte(8'h01);
    @(posedge clk); #1;
    probe_in = 32'h1100_FF22;
    wait_idle("snap");
    chk("snap_txcnt", 32'(tx_cnt - tx0), 32'd1);
    chk("snap_rsp", 32'(tx_val), 32'h3C);
    run_cmd("probe3", 2, 8'h52, 8'h03, 8'h00, 8'h11, 0);

    run_cmd("bad_op", 1, 8'h58, 8'h00, 8'h00, 8'h15, 1);
    run_cmd("bad_raddr", 2, 8'h52, 8'h07, 8'h00, 8'h15, 1);
    run_cmd("bad_caddr", 2, 8'h43, 8'h04, 8'h00, 8'h15, 1);
    run_cmd("bad_waddr", 3, 8'h57, 8'h09, 8'h11, 8'h15, 1);
    chk("bad_waddr_ctrl", ctrl_out, 32'h00A5_0000);

    // drop while stuck in SEND
    hold_busy = 1'b1;
    tx0  = tx_cnt;
    err0 = err_cnt;
    send_byte(8'h50);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_busy", 32'(busy), 32'd1);
    send_byte(8'h50);
    repeat (3) @(negedge clk);
    chk("drop_err", 32'(err_cnt - err0), 32'd1);
    chk("drop_notx", 32'(tx_cnt - tx0), 32'd0);
    hold_busy = 1'b0;
    wait_idle("drop");
    repeat (20) @(negedge clk);
    chk("drop_txcnt", 32'(tx_cnt - tx0), 32'd1);
    chk("drop_rsp", 32'(tx_val), 32'h4B);
    chk("drop_idle", 32'(busy), 32'd0);

    // reset in the middle of a write
    tx0 = tx_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    #1;
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ctrl", ctrl_out, 32'h0);
    chk("midrst_transmit", 32'(u_if.transmit), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_notx", 32'(tx_cnt - tx0), 32'd0);
    chk("midrst_ctrl2", ctrl_out, 32'h0);
    run_cmd("post_rst_ping", 1, 8'h50, 8'h00, 8'h00, 8'h4B, 0);

    // inter-byte silence
    tx0  = tx_cnt;
    err0 = err_cnt;
    send_byte(8'h52);
    repeat (105) @(negedge clk);
`ifdef UART_DEBUG_CMD_TIMEOUT_EN
    chk("tmo_err", 32'(err_cnt - err0), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_notx", 32'(tx_cnt - tx0), 32'd0);
`else
    chk("notmo_busy", 32'(busy), 32'd1);
    chk("notmo_err", 32'(err_cnt - err0), 32'd0);
    send_byte(8'h00);
    wait_idle("notmo");
    repeat (2) @(negedge clk);
    chk("notmo_txcnt", 32'(tx_cnt - tx0), 32'd1);
    chk("notmo_rsp", 32'(tx_val), 32'h22);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
